// File: rtl/ntt_seq_ctrl.sv
// Sequencer in front of the NTTN core: host stream -> NTTN load/start pins -> result re-stream.
// Optional done watchdog is built when NTT_TIMEOUT_EN is defined.
//
// state      | meaning
// IDLE       | waiting for tw_req or a transform request
// LDW_PULSE  | ntt_load_w high for one cycle once the first word is valid
// LDW_STREAM | twiddle tables + params forwarded to ntt_din
// LDD_PULSE  | ntt_load_data high for one cycle once the first word is valid
// LDD_STREAM | coefficients forwarded to ntt_din
// GAP        | idle cycles before the start pulse
// START      | ntt_start or ntt_start_intt for one cycle
// WAIT_DONE  | waiting for ntt_done
// DRAIN      | re-streaming ntt_dout as out_data
module ntt_seq_ctrl #(
  parameter int DATA_SIZE  = 64,
  parameter int RING_DEPTH = 12,
  parameter int PE_DEPTH   = 3,
  parameter int GAP_CYC    = 5
`ifdef NTT_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1 << 20
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tw_req,
  input  logic                 op_valid,
  input  logic                 op_intt,
  output logic                 op_ready,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_last,
  output logic                 ntt_load_w,
  output logic                 ntt_load_data,
  output logic                 ntt_start,
  output logic                 ntt_start_intt,
  output logic [DATA_SIZE-1:0] ntt_din,
  input  logic                 ntt_done,
  input  logic [DATA_SIZE-1:0] ntt_dout,
  output logic                 busy,
  output logic                 tw_loaded,
  output logic                 err
);

  localparam int RING_SIZE = 1 << RING_DEPTH;
  localparam int TW_WORDS  = ((1 << (RING_DEPTH - PE_DEPTH)) - 1 + PE_DEPTH) << PE_DEPTH;
  localparam int LDW_N     = 2 * TW_WORDS + 2;
  localparam int MAX_N     = (LDW_N > RING_SIZE) ? LDW_N : RING_SIZE;
  localparam int CNT_W     = $clog2(MAX_N);
  localparam int GAP_W     = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam logic [CNT_W-1:0] LDW_LAST = CNT_W'(LDW_N - 1);
  localparam logic [CNT_W-1:0] LDD_LAST = CNT_W'(RING_SIZE - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, LDW_PULSE, LDW_STREAM, LDD_PULSE, LDD_STREAM, GAP, START, WAIT_DONE, DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   intt_q, intt_d;
  logic                   tw_loaded_q, tw_loaded_d;
  logic                   err_q, err_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [DATA_SIZE-1:0]   out_data_q, out_data_d;
`ifdef NTT_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0]        wd_q, wd_d;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    gap_d          = gap_q;
    intt_d         = intt_q;
    tw_loaded_d    = tw_loaded_q;
    err_d          = err_q;
    out_valid_d    = 1'b0;
    out_last_d     = 1'b0;
    out_data_d     = out_data_q;
`ifdef NTT_TIMEOUT_EN
    wd_d           = wd_q;
`endif
    op_ready       = 1'b0;
    in_ready       = 1'b0;
    ntt_load_w     = 1'b0;
    ntt_load_data  = 1'b0;
    ntt_start      = 1'b0;
    ntt_start_intt = 1'b0;
    ntt_din        = '0;

    case (state_q)
      IDLE: begin
        op_ready = tw_loaded_q & ~tw_req;
        if (tw_req) begin
          // tables are being overwritten, so they stay invalid until the reload completes
          state_d     = LDW_PULSE;
          err_d       = 1'b0;
          tw_loaded_d = 1'b0;
        end else if (op_valid && tw_loaded_q) begin
          intt_d  = op_intt;
          state_d = LDD_PULSE;
        end
      end
      LDW_PULSE: begin
        if (in_valid) begin
          ntt_load_w = 1'b1;
          cnt_d      = '0;
          state_d    = LDW_STREAM;
        end
      end
      LDW_STREAM: begin
        in_ready = 1'b1;
        ntt_din  = in_data;
        if (!in_valid) begin
          err_d       = 1'b1;
          tw_loaded_d = 1'b0;
          state_d     = IDLE;
        end else if (cnt_q == LDW_LAST) begin
          tw_loaded_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LDD_PULSE: begin
        if (in_valid) begin
          ntt_load_data = 1'b1;
          cnt_d         = '0;
          state_d       = LDD_STREAM;
        end
      end
      LDD_STREAM: begin
        in_ready = 1'b1;
        ntt_din  = in_data;
        if (!in_valid) begin
          err_d       = 1'b1;
          tw_loaded_d = 1'b0;
          state_d     = IDLE;
        end else if (cnt_q == LDD_LAST) begin
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = START;
        else             gap_d   = gap_q - 1'b1;
      end
      START: begin
        ntt_start      = ~intt_q;
        ntt_start_intt = intt_q;
        state_d        = WAIT_DONE;
`ifdef NTT_TIMEOUT_EN
        wd_d           = WD_LOAD;
`endif
      end
      WAIT_DONE: begin
        if (ntt_done) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
`ifdef NTT_TIMEOUT_EN
        else if (wd_q == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q - 1'b1;
        end
`endif
      end
      DRAIN: begin
        // one extra cycle so busy covers the cycle that presents out_last
        if (out_last_q) begin
          state_d = IDLE;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = ntt_dout;
          out_last_d  = (cnt_q == LDD_LAST);
          if (cnt_q != LDD_LAST) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      intt_q      <= 1'b0;
      tw_loaded_q <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
`ifdef NTT_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      intt_q      <= intt_d;
      tw_loaded_q <= tw_loaded_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
`ifdef NTT_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign tw_loaded = tw_loaded_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Scoreboard bench for ntt_seq_ctrl with a behavioural NTTN stub on the pin side.
// Timeout checks are compiled only when NTT_TIMEOUT_EN is defined.
module tb_ntt_seq_ctrl;
  localparam int DW   = 32;
  localparam int TW   = 16;
  localparam int TW_N = 2 * TW + 2;
  localparam int RS   = 16;
  localparam int LAT  = 7;
`ifdef NTT_TIMEOUT_EN
  localparam int TO_CYC = 64;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tw_req = 1'b0, op_valid = 1'b0, op_intt = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          op_ready, in_ready, out_valid, out_last;
  logic [DW-1:0] out_data, ntt_din;
  logic          ntt_load_w, ntt_load_data, ntt_start, ntt_start_intt;
  logic          ntt_done = 1'b0;
  logic [DW-1:0] ntt_dout = '0;
  logic          busy, tw_loaded, err;

  ntt_seq_ctrl #(
    .DATA_SIZE(DW), .RING_DEPTH(4), .PE_DEPTH(1), .GAP_CYC(5)
`ifdef NTT_TIMEOUT_EN
    , .TIMEOUT_CYC(TO_CYC)
`endif
  ) dut (
    .clk(clk), .reset(reset), .tw_req(tw_req), .op_valid(op_valid), .op_intt(op_intt),
    .op_ready(op_ready), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .ntt_load_w(ntt_load_w), .ntt_load_data(ntt_load_data), .ntt_start(ntt_start),
    .ntt_start_intt(ntt_start_intt), .ntt_din(ntt_din), .ntt_done(ntt_done),
    .ntt_dout(ntt_dout), .busy(busy), .tw_loaded(tw_loaded), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic checkd(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic checki(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // host vectors
  logic [DW-1:0] tw_vec [TW_N];
  logic [DW-1:0] cf_vec [RS];
  logic [DW-1:0] cf2_vec[RS];

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          first;
  } exp_t;
  exp_t sb[$];

  // NTTN stub state
  logic [DW-1:0] tw_cap [TW_N];
  logic [DW-1:0] cf_cap [RS];
  logic [DW-1:0] res    [RS];
  int cap_mode = 0, cap_idx = 0, cap_n = 0;
  int n_ldw = 0, n_ldd = 0, n_st = 0, n_sti = 0;
  int ldd_cyc = 0, start_cyc = 0, done_cyc = 0, done_at = -1, out_idx = 0;
  logic streaming = 1'b0, spur = 1'b0, no_done = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (cap_mode != 0 && cap_idx < cap_n) begin
        if (cap_mode == 1) tw_cap[cap_idx] = ntt_din;
        else               cf_cap[cap_idx] = ntt_din;
        cap_idx++;
      end
      if (ntt_load_w) begin
        n_ldw++; cap_mode = 1; cap_idx = 0; cap_n = TW_N;
      end
      if (ntt_load_data) begin
        n_ldd++; cap_mode = 2; cap_idx = 0; cap_n = RS; ldd_cyc = cyc;
      end
      if (ntt_start || ntt_start_intt) begin
        start_cyc = cyc;
        if (ntt_start) n_st++;
        if (ntt_start_intt) n_sti++;
        for (int m = 0; m < RS; m++)
          res[m] = ntt_start_intt ? (cf_cap[m] ^ tw_cap[TW+m]) : (cf_cap[RS-1-m] + tw_cap[m]);
        if (!no_done) done_at = cyc + LAT;
      end
      ntt_done = 1'b0;
      ntt_dout = '0;
      if (spur) begin
        ntt_done = 1'b1;
        spur = 1'b0;
      end
      if (cyc == done_at) begin
        ntt_done  = 1'b1;
        done_cyc  = cyc;
        done_at   = -1;
        out_idx   = 0;
        streaming = 1'b1;
      end else if (streaming) begin
        ntt_dout = res[out_idx];
        out_idx++;
        if (out_idx == RS) streaming = 1'b0;
      end
    end
  end

  // monitor
  int prev_out_cyc = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got word %0h with empty scoreboard (cycle %0d)", out_data, cyc);
        end else begin
          e = sb.pop_front();
          checkd("out_data", out_data, e.data);
          check1("out_last", out_last, e.last);
          if (e.first) checki("out_latency", cyc, done_cyc + 2);
          else         checki("out_gapless", cyc, prev_out_cyc + 1);
        end
        prev_out_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] word(input int kind, input int k);
    if (kind == 0)      return tw_vec[k];
    else if (kind == 1) return cf_vec[k];
    else                return cf2_vec[k];
  endfunction

  // streams words; stops early (in_valid still high) when k reaches stop_at
  task automatic send_words(input int kind, input int stop_at);
    int   n;
    int   k;
    int   b;
    logic acc;
    n = (kind == 0) ? TW_N : RS;
    k = 0;
    b = 0;
    while (k < n && k != stop_at && b < 200) begin
      in_valid = 1'b1;
      in_data  = word(kind, k);
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) k++;
      b++;
    end
    if (b >= 200) timeout_fail("send_words");
  endtask

  task automatic wait_idle(input string name, output int t);
    int b;
    b = 0;
    @(negedge clk);
    while (busy && b < 500) begin
      @(negedge clk);
      b++;
    end
    t = cyc;
    if (busy) timeout_fail(name);
  endtask

  task automatic reload_tw();
    tick();
    tw_req = 1'b1; in_valid = 1'b1; in_data = tw_vec[0];
    tick();
    tw_req = 1'b0;
    send_words(0, -1);
    in_valid = 1'b0;
  endtask

  task automatic start_op(input logic intt, input int kind);
    tick();
    op_valid = 1'b1; op_intt = intt; in_valid = 1'b1; in_data = word(kind, 0);
    @(negedge clk);
    check1("op_ready_accept", op_ready, 1'b1);
    tick();
    op_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    exp_t e;
    int t;
    int ldw0, ldd0, st0;
    for (int k = 0; k < TW_N; k++) tw_vec[k] = 32'(32'h1000 + 7 * k);
    for (int k = 0; k < RS; k++) begin
      cf_vec[k]  = 32'(3 * k + 1);
      cf2_vec[k] = 32'(32'h50 + 11 * k);
    end

    // reset state, op request without tables
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    op_valid = 1'b1;
    @(negedge clk);
    check1("rst_busy", busy, 1'b0);
    check1("rst_tw_loaded", tw_loaded, 1'b0);
    check1("rst_err", err, 1'b0);
    check1("rst_op_ready", op_ready, 1'b0);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_load_w", ntt_load_w, 1'b0);
    check1("rst_start", ntt_start, 1'b0);
    checkd("rst_din", ntt_din, '0);
    repeat (3) @(negedge clk);
    checki("no_op_without_tw", n_ldd, 0);
    op_valid = 1'b0;

    // twiddle load
    reload_tw();
    @(negedge clk);
    check1("ldw_tw_loaded", tw_loaded, 1'b1);
    check1("ldw_busy", busy, 1'b0);
    checki("ldw_pulses", n_ldw, 1);
    checki("ldw_cap_count", cap_idx, TW_N);
    for (int k = 0; k < TW_N; k++) checkd("ldw_din", tw_cap[k], tw_vec[k]);

    // NTT
    start_op(1'b0, 1);
    for (int m = 0; m < RS; m++) begin
      e.data = 32'(32'h102E + 4 * m); e.last = (m == RS - 1); e.first = (m == 0);
      sb.push_back(e);
    end
    send_words(1, -1);
    in_valid = 1'b0;
    wait_idle("ntt_idle", t);
    @(negedge clk);
    checki("ntt_sb_drained", sb.size(), 0);
    checki("ntt_start_pulses", n_st, 1);
    checki("ntt_intt_pulses", n_sti, 0);
    checki("ntt_gap", start_cyc, ldd_cyc + RS + 6);

    // done while idle is ignored
    tick();
    spur = 1'b1;
    repeat (4) @(negedge clk);
    check1("spur_busy", busy, 1'b0);

    // INTT
    start_op(1'b1, 2);
    for (int m = 0; m < RS; m++) begin
      e.data = cf2_vec[m] ^ tw_vec[TW + m]; e.last = (m == RS - 1); e.first = (m == 0);
      sb.push_back(e);
    end
    send_words(2, -1);
    in_valid = 1'b0;
    wait_idle("intt_idle", t);
    @(negedge clk);
    checki("intt_sb_drained", sb.size(), 0);
    checki("intt_start_pulses", n_st, 1);
    checki("intt_intt_pulses", n_sti, 1);
    checki("intt_gap", start_cyc, ldd_cyc + RS + 6);

    // in_valid dropped at coefficient word 7
    ldd0 = n_ldd;
    st0  = n_st + n_sti;
    start_op(1'b0, 1);
    send_words(1, 7);
    in_valid = 1'b0;
    tick();
    op_valid = 1'b1;
    @(negedge clk);
    check1("drop_err", err, 1'b1);
    check1("drop_tw_loaded", tw_loaded, 1'b0);
    check1("drop_busy", busy, 1'b0);
    check1("drop_op_ready", op_ready, 1'b0);
    repeat (3) @(negedge clk);
    checki("drop_no_reload_data", n_ldd, ldd0 + 1);
    checki("drop_no_start", n_st + n_sti, st0);
    op_valid = 1'b0;
    tick();
    tw_req = 1'b1; in_valid = 1'b1; in_data = tw_vec[0];
    tick();
    tw_req = 1'b0;
    @(negedge clk);
    check1("reload_err_cleared", err, 1'b0);
    send_words(0, -1);
    in_valid = 1'b0;
    @(negedge clk);
    check1("reload_tw_loaded", tw_loaded, 1'b1);
    check1("reload_op_ready", op_ready, 1'b1);

    // tw_req and op_valid in the same idle cycle
    ldw0 = n_ldw;
    ldd0 = n_ldd;
    tick();
    tw_req = 1'b1; op_valid = 1'b1; op_intt = 1'b0; in_valid = 1'b1; in_data = tw_vec[0];
    @(negedge clk);
    check1("prio_op_ready", op_ready, 1'b0);
    tick();
    tw_req = 1'b0; op_valid = 1'b0;
    send_words(0, -1);
    in_valid = 1'b0;
    @(negedge clk);
    checki("prio_ldw", n_ldw, ldw0 + 1);
    checki("prio_ldd", n_ldd, ldd0);
    check1("prio_tw_loaded", tw_loaded, 1'b1);

`ifdef NTT_TIMEOUT_EN
    // done never arrives
    no_done = 1'b1;
    st0 = n_st;
    start_op(1'b0, 1);
    send_words(1, -1);
    in_valid = 1'b0;
    wait_idle("to_idle", t);
    checki("to_start", n_st, st0 + 1);
    checki("to_cycle", t, start_cyc + 1 + TO_CYC);
    check1("to_err", err, 1'b1);
    check1("to_tw_loaded", tw_loaded, 1'b1);
    no_done = 1'b0;
`endif

    // reset mid coefficient stream
    start_op(1'b0, 1);
    send_words(1, 5);
    #2 reset = 1'b0;
    #1;
    check1("amid_busy", busy, 1'b0);
    check1("amid_tw_loaded", tw_loaded, 1'b0);
    check1("amid_err", err, 1'b0);
    check1("amid_in_ready", in_ready, 1'b0);
    check1("amid_out_valid", out_valid, 1'b0);
    check1("amid_load_data", ntt_load_data, 1'b0);
    checkd("amid_din", ntt_din, '0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    op_valid = 1'b1;
    repeat (3) @(negedge clk);
    check1("post_rst_op_ready", op_ready, 1'b0);
    check1("post_rst_busy", busy, 1'b0);
    op_valid = 1'b0;

    @(negedge clk);
    checki("final_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
